// File: rtl/led_pkg.sv
// Shared types for the RGB LED PWM controller: mode encoding, ramp direction
// and the mode stepping rule used by the mode FSM.
package led_pkg;

  localparam int unsigned MODE_COUNT = 8;
  localparam int unsigned MODE_W     = $clog2(MODE_COUNT);

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF      = 3'd0,
    MODE_RED      = 3'd1,
    MODE_GREEN    = 3'd2,
    MODE_BLUE     = 3'd3,
    MODE_BR_RED   = 3'd4,
    MODE_BR_GREEN = 3'd5,
    MODE_BR_BLUE  = 3'd6,
    MODE_BR_WHITE = 3'd7
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Modulo-8 step; simultaneous next/prev cancel out.
  function automatic mode_e mode_step(input mode_e m, input logic nxt, input logic prv);
    mode_e r;
    r = m;
    if (nxt && !prv) begin
      r = mode_e'(MODE_W'(m + MODE_W'(1)));
    end else if (prv && !nxt) begin
      r = mode_e'(MODE_W'(m - MODE_W'(1)));
    end
    return r;
  endfunction

endpackage

// File: rtl/led_breath_ramp.sv
// Triangular breathing ramp: level walks 0..max..0 one step every STEP_CYCLES
// clocks, without repeating either endpoint.
module led_breath_ramp
  import led_pkg::*;
#(
  parameter int unsigned PWM_BITS    = 8,
  parameter int unsigned STEP_CYCLES = 23437
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_clr,
  output logic [PWM_BITS-1:0] o_level
);

  localparam int unsigned          STEP_W    = $clog2(STEP_CYCLES);
  localparam logic [STEP_W-1:0]    STEP_LAST = STEP_W'(STEP_CYCLES - 1);
  localparam logic [PWM_BITS-1:0]  LEVEL_MAX = '1;

  logic [STEP_W-1:0]   r_step_cnt;
  logic [PWM_BITS-1:0] r_level;
  dir_e                r_dir;

  logic                w_step;
  logic [PWM_BITS-1:0] w_level_next;

  always_comb begin
    w_step       = (r_step_cnt == STEP_LAST);
    w_level_next = (r_dir == DIR_UP) ? (r_level + PWM_BITS'(1))
                                     : (r_level - PWM_BITS'(1));
  end

  // Direction flips on the step that lands on an endpoint.
  always_ff @(posedge clk) begin
    if (!rst_n || i_clr) begin
      r_step_cnt <= '0;
      r_level    <= '0;
      r_dir      <= DIR_UP;
    end else if (w_step) begin
      r_step_cnt <= '0;
      r_level    <= w_level_next;
      if (w_level_next == LEVEL_MAX) begin
        r_dir <= DIR_DOWN;
      end else if (w_level_next == '0) begin
        r_dir <= DIR_UP;
      end
    end else begin
      r_step_cnt <= r_step_cnt + STEP_W'(1);
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/led_pwm_ctrl.sv
// RGB LED controller: button-driven 8-entry mode FSM, breathing ramp and three
// glitch-free PWM channels sharing one free-running counter.
module led_pwm_ctrl
  import led_pkg::*;
#(
  parameter int unsigned PWM_BITS    = 8,
  parameter int unsigned STEP_CYCLES = 23437,
  parameter int unsigned STEADY_DUTY = 128
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                btn_next_i,
  input  logic                btn_prev_i,
  output logic                pwm_red,
  output logic                pwm_green,
  output logic                pwm_blue,
  output logic [MODE_W-1:0]   mode,
  output logic [PWM_BITS-1:0] level
);

  localparam logic [PWM_BITS-1:0] STEADY = PWM_BITS'(STEADY_DUTY);

  logic                r_btn_next_q;
  logic                r_btn_prev_q;
  mode_e               r_mode;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [PWM_BITS-1:0] r_duty_r;
  logic [PWM_BITS-1:0] r_duty_g;
  logic [PWM_BITS-1:0] r_duty_b;
  logic                r_pwm_r;
  logic                r_pwm_g;
  logic                r_pwm_b;

  logic                w_next_press;
  logic                w_prev_press;
  mode_e               w_mode_next;
  logic                w_mode_chg;
  logic [PWM_BITS-1:0] w_level;
  logic [PWM_BITS-1:0] w_duty_r;
  logic [PWM_BITS-1:0] w_duty_g;
  logic [PWM_BITS-1:0] w_duty_b;

  // Edge detectors reset high so a button held through reset is ignored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_btn_next_q <= 1'b1;
      r_btn_prev_q <= 1'b1;
    end else begin
      r_btn_next_q <= btn_next_i;
      r_btn_prev_q <= btn_prev_i;
    end
  end

  assign w_next_press = btn_next_i & ~r_btn_next_q;
  assign w_prev_press = btn_prev_i & ~r_btn_prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mode <= MODE_OFF;
    end else begin
      r_mode <= w_mode_next;
    end
  end

  always_comb begin
    w_mode_next = r_mode;
    w_mode_chg  = 1'b0;
    if (w_next_press ^ w_prev_press) begin
      w_mode_next = mode_step(r_mode, w_next_press, w_prev_press);
      w_mode_chg  = 1'b1;
    end
  end

  led_breath_ramp #(
    .PWM_BITS    (PWM_BITS),
    .STEP_CYCLES (STEP_CYCLES)
  ) u_ramp (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_mode_chg),
    .o_level (w_level)
  );

  always_comb begin
    w_duty_r = '0;
    w_duty_g = '0;
    w_duty_b = '0;
    case (r_mode)
      MODE_RED:      w_duty_r = STEADY;
      MODE_GREEN:    w_duty_g = STEADY;
      MODE_BLUE:     w_duty_b = STEADY;
      MODE_BR_RED:   w_duty_r = w_level;
      MODE_BR_GREEN: w_duty_g = w_level;
      MODE_BR_BLUE:  w_duty_b = w_level;
      MODE_BR_WHITE: begin
        w_duty_r = w_level;
        w_duty_g = w_level;
        w_duty_b = w_level;
      end
      default: ;
    endcase
  end

  // Duty is latched only at the counter wrap so every period is whole.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pwm_cnt <= '0;
      r_duty_r  <= '0;
      r_duty_g  <= '0;
      r_duty_b  <= '0;
      r_pwm_r   <= 1'b0;
      r_pwm_g   <= 1'b0;
      r_pwm_b   <= 1'b0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
      if (r_pwm_cnt == '1) begin
        r_duty_r <= w_duty_r;
        r_duty_g <= w_duty_g;
        r_duty_b <= w_duty_b;
      end
      r_pwm_r <= (r_pwm_cnt < r_duty_r);
      r_pwm_g <= (r_pwm_cnt < r_duty_g);
      r_pwm_b <= (r_pwm_cnt < r_duty_b);
    end
  end

  assign pwm_red   = r_pwm_r;
  assign pwm_green = r_pwm_g;
  assign pwm_blue  = r_pwm_b;
  assign mode      = r_mode;
  assign level     = w_level;

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Directed bench for led_pwm_ctrl with a short breathing step (4 clocks).
module tb_led_pwm_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_next;
  logic       btn_prev;
  logic       pwm_red;
  logic       pwm_green;
  logic       pwm_blue;
  logic [2:0] mode;
  logic [7:0] level;

  int         n_checks = 0;
  int         n_bad    = 0;
  logic [7:0] m_cnt    = 8'd0;
  int         edges    = 0;

  led_pwm_ctrl #(
    .PWM_BITS    (8),
    .STEP_CYCLES (4),
    .STEADY_DUTY (128)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_next_i (btn_next),
    .btn_prev_i (btn_prev),
    .pwm_red    (pwm_red),
    .pwm_green  (pwm_green),
    .pwm_blue   (pwm_blue),
    .mode       (mode),
    .level      (level)
  );

  always #5 clk = ~clk;

  // Reference copy of the free-running PWM counter and an edge counter.
  always @(posedge clk) begin
    edges <= edges + 1;
    if (!rst_n) m_cnt <= 8'd0;
    else        m_cnt <= m_cnt + 8'd1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic drive_press(input logic n, input logic p);
    btn_next = n;
    btn_prev = p;
    tick(1);
  endtask

  task automatic release_btns();
    btn_next = 1'b0;
    btn_prev = 1'b0;
    tick(1);
  endtask

  task automatic wait_cnt(input logic [7:0] tgt, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (m_cnt == tgt) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  task automatic count_window(input int n, output int r, output int g, output int b);
    r = 0; g = 0; b = 0;
    for (int i = 0; i < n; i++) begin
      r += int'(pwm_red);
      g += int'(pwm_green);
      b += int'(pwm_blue);
      tick(1);
    end
  endtask

  function automatic int tri_level(input int k);
    int m;
    m = k % 510;
    return (m <= 255) ? m : 510 - m;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; btn_next = 1'b1; btn_prev = 1'b1;
    @(negedge clk);
    tick(2);
    n_checks++; if (mode !== 3'd0) begin n_bad++; $display("FAIL reset_mode got=%0d want=0", mode); end
    n_checks++; if (level !== 8'd0) begin n_bad++; $display("FAIL reset_level got=%0d want=0", level); end
    n_checks++; if ({pwm_red, pwm_green, pwm_blue} !== 3'b000) begin
      n_bad++; $display("FAIL reset_pwm got=%b want=000", {pwm_red, pwm_green, pwm_blue}); end
    rst_n = 1'b1;
    tick(3);
    n_checks++; if (mode !== 3'd0) begin n_bad++; $display("FAIL held_thru_reset got=%0d want=0", mode); end
    release_btns();
    n_checks++; if (mode !== 3'd0) begin n_bad++; $display("FAIL release_mode got=%0d want=0", mode); end
    drive_press(1'b1, 1'b0);
    n_checks++; if (mode !== 3'd1) begin n_bad++; $display("FAIL first_next got=%0d want=1", mode); end
    release_btns();
  endtask

  task automatic test_steady();
    int r, g, b;
    tick(512);
    count_window(256, r, g, b);
    n_checks++; if (r != 128) begin n_bad++; $display("FAIL steady_red_highs got=%0d want=128", r); end
    n_checks++; if (g != 0) begin n_bad++; $display("FAIL steady_green_highs got=%0d want=0", g); end
    n_checks++; if (b != 0) begin n_bad++; $display("FAIL steady_blue_highs got=%0d want=0", b); end
  endtask

  task automatic test_wrap();
    drive_press(1'b0, 1'b1);
    n_checks++; if (mode !== 3'd0) begin n_bad++; $display("FAIL prev_1_to_0 got=%0d want=0", mode); end
    release_btns();
    drive_press(1'b0, 1'b1);
    n_checks++; if (mode !== 3'd7) begin n_bad++; $display("FAIL prev_wrap got=%0d want=7", mode); end
    release_btns();
    drive_press(1'b1, 1'b0);
    n_checks++; if (mode !== 3'd0) begin n_bad++; $display("FAIL next_wrap got=%0d want=0", mode); end
    release_btns();
    drive_press(1'b1, 1'b1);
    n_checks++; if (mode !== 3'd0) begin n_bad++; $display("FAIL both_pressed got=%0d want=0", mode); end
    release_btns();
    drive_press(1'b1, 1'b0);
    n_checks++; if (mode !== 3'd1) begin n_bad++; $display("FAIL held_first got=%0d want=1", mode); end
    tick(3);
    n_checks++; if (mode !== 3'd1) begin n_bad++; $display("FAIL held_repeat got=%0d want=1", mode); end
    release_btns();
    drive_press(1'b0, 1'b1);
    n_checks++; if (mode !== 3'd0) begin n_bad++; $display("FAIL held_back got=%0d want=0", mode); end
    release_btns();
  endtask

  task automatic test_mid_period();
    bit ok;
    bit wrapped;
    int rc, gbw, gt, bt;
    drive_press(1'b1, 1'b0);
    release_btns();
    tick(512);
    wait_cnt(8'd50, ok);
    n_checks++; if (!ok) begin n_bad++; $display("FAIL mid_wait got=timeout want=cnt50"); end
    drive_press(1'b1, 1'b0);
    n_checks++; if (mode !== 3'd2) begin n_bad++; $display("FAIL mid_mode got=%0d want=2", mode); end
    btn_next = 1'b0;
    wrapped = 1'b0; rc = 0; gbw = 0; gt = 0; bt = 0;
    for (int i = 0; i < 256; i++) begin
      if (m_cnt == 8'd0) wrapped = 1'b1;
      rc += int'(pwm_red);
      gt += int'(pwm_green);
      bt += int'(pwm_blue);
      if (!wrapped) gbw += int'(pwm_green);
      tick(1);
    end
    n_checks++; if (rc != 78) begin n_bad++; $display("FAIL mid_red_tail got=%0d want=78", rc); end
    n_checks++; if (gbw != 0) begin n_bad++; $display("FAIL mid_green_early got=%0d want=0", gbw); end
    n_checks++; if (gt != 50) begin n_bad++; $display("FAIL mid_green_new got=%0d want=50", gt); end
    n_checks++; if (bt != 0) begin n_bad++; $display("FAIL mid_blue got=%0d want=0", bt); end
  endtask

  task automatic test_breathe();
    int e0, e_at, exp_d, r, g, b;
    bit ok;
    drive_press(1'b1, 1'b0);
    release_btns();
    btn_next = 1'b1;
    tick(1);
    e0 = edges;
    n_checks++; if (mode !== 3'd4) begin n_bad++; $display("FAIL br_mode got=%0d want=4", mode); end
    n_checks++; if (level !== 8'd0) begin n_bad++; $display("FAIL br_clear got=%0d want=0", level); end
    btn_next = 1'b0;
    tick(3);
    n_checks++; if (level !== 8'd0) begin n_bad++; $display("FAIL br_pre_step got=%0d want=0", level); end
    tick(1);
    n_checks++; if (level !== 8'd1) begin n_bad++; $display("FAIL br_first_step got=%0d want=1", level); end
    tick(1015);
    n_checks++; if (level !== 8'd254) begin n_bad++; $display("FAIL br_1019 got=%0d want=254", level); end
    tick(1);
    n_checks++; if (level !== 8'd255) begin n_bad++; $display("FAIL br_peak got=%0d want=255", level); end
    tick(3);
    n_checks++; if (level !== 8'd255) begin n_bad++; $display("FAIL br_peak_hold got=%0d want=255", level); end
    tick(1);
    n_checks++; if (level !== 8'd254) begin n_bad++; $display("FAIL br_turn got=%0d want=254", level); end
    wait_cnt(8'd255, ok);
    n_checks++; if (!ok) begin n_bad++; $display("FAIL br_wait got=timeout want=cnt255"); end
    e_at  = edges;
    exp_d = tri_level((e_at - e0) / 4);
    tick(1);
    count_window(256, r, g, b);
    n_checks++; if (r != exp_d) begin n_bad++; $display("FAIL br_red_duty got=%0d want=%0d", r, exp_d); end
    n_checks++; if (g != 0 || b != 0) begin n_bad++; $display("FAIL br_other got=%0d/%0d want=0/0", g, b); end
  endtask

  task automatic test_white_reset();
    int e0, e_at, exp_d, r, g, b;
    bit ok;
    drive_press(1'b1, 1'b0); release_btns();
    drive_press(1'b1, 1'b0); release_btns();
    drive_press(1'b1, 1'b0);
    e0 = edges;
    release_btns();
    n_checks++; if (mode !== 3'd7) begin n_bad++; $display("FAIL white_mode got=%0d want=7", mode); end
    wait_cnt(8'd255, ok);
    n_checks++; if (!ok) begin n_bad++; $display("FAIL white_wait got=timeout want=cnt255"); end
    e_at  = edges;
    exp_d = tri_level((e_at - e0) / 4);
    tick(1);
    count_window(256, r, g, b);
    n_checks++; if (r != exp_d || g != exp_d || b != exp_d) begin
      n_bad++; $display("FAIL white_duty got=%0d/%0d/%0d want=%0d", r, g, b, exp_d); end
    drive_press(1'b0, 1'b1); release_btns();
    drive_press(1'b1, 1'b0);
    btn_next = 1'b0;
    tick(400);
    n_checks++; if (level !== 8'd100 || mode !== 3'd7) begin
      n_bad++; $display("FAIL white_l100 got=%0d/%0d want=100/7", level, mode); end
    rst_n = 1'b0;
    tick(1);
    n_checks++; if (level !== 8'd0) begin n_bad++; $display("FAIL midrst_level got=%0d want=0", level); end
    n_checks++; if (mode !== 3'd0) begin n_bad++; $display("FAIL midrst_mode got=%0d want=0", mode); end
    n_checks++; if ({pwm_red, pwm_green, pwm_blue} !== 3'b000) begin
      n_bad++; $display("FAIL midrst_pwm got=%b want=000", {pwm_red, pwm_green, pwm_blue}); end
    rst_n = 1'b1;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_steady();
    test_wrap();
    test_mid_period();
    test_breathe();
    test_white_reset();
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/led_pwm_ctrl.md
# led_pwm_ctrl

Output-side companion to the pad-button sampler: consumes the debounced button levels and produces the three PWM drive signals for the RGB LED hard driver (RGBxPWM inputs). It holds an 8-entry colour/effect mode selected by "next"/"prev" button presses, generates a triangular breathing ramp, and converts per-channel duty values into glitch-free PWM. It sits between the two button instances and the LED driver primitive in the top level.

## Interface
- PWM_BITS, 8: PWM counter and duty width; PWM period is 2^PWM_BITS clocks.
- STEP_CYCLES, 23437: clocks per breathing level step (≥2). At 48 MHz this gives a breathing period of about 0.25 s.
- STEADY_DUTY, 128: duty used by the steady modes (< 2^PWM_BITS).

- clk, input, 1: system clock, 48 MHz global buffer.
- rst_n, input, 1: reset, synchronous, active-low.
- btn_next_i, input, 1: debounced level, high = pressed.
- btn_prev_i, input, 1: debounced level, high = pressed.
- pwm_red, output, 1: red PWM drive, registered.
- pwm_green, output, 1: green PWM drive, registered.
- pwm_blue, output, 1: blue PWM drive, registered.
- mode, output, 3: current mode, registered.
- level, output, PWM_BITS: current breathing level, registered.

## Operation
- Modes:
  - 0 OFF
  - 1 RED steady
  - 2 GREEN steady
  - 3 BLUE steady
  - 4 BREATHE_RED
  - 5 BREATHE_GREEN
  - 6 BREATHE_BLUE
  - 7 BREATHE_WHITE
- Edge detect: each button has a registered copy `btn_q`, reset to 1 so that a button held through reset produces no event. A press is `btn_i & ~btn_q`.
- Mode transitions:
  - Next press only: `mode` +1, wrapping 7→0.
  - Prev press only: `mode` −1, wrapping 0→7.
  - Both presses at the same edge: no change.
  - A held button produces exactly one step.
- Target duty per channel:
  - OFF: all channels 0.
  - Steady modes: the selected channel is STEADY_DUTY; the others are 0.
  - Breathe modes: the selected channel(s) equal `level`; the others are 0. Mode 7 drives all three channels.
- Breathing ramp:
  - A step counter counts 0..STEP_CYCLES−1.
  - On the terminal count, `level` moves by 1 in direction `dir`.
  - When `level` reaches 2^PWM_BITS−1, `dir` flips to down. When it reaches 0, `dir` flips to up.
  - Resulting sequence: 0, 1, …, 255, 254, …, 1, 0, 1, … There is no repeated endpoint.
  - The ramp runs in every mode. Any mode change clears `level`, `dir` (up) and the step counter at the same edge that updates `mode`.
- PWM:
  - One free-running counter `pwm_cnt` is shared by all three channels.
  - Per-channel `duty_q` loads the target duty only on the edge where `pwm_cnt` is all-ones, so the new duty takes effect from count 0. There are no mid-period glitches.
  - Output rule: `pwm_x <= (pwm_cnt < duty_q_x)`.
  - Duty 0 gives a constant low output. Duty 255 gives high for 255 of every 256 clocks.
- Reset (rst_n low at an edge):
  - `mode` = 0, `level` = 0, `dir` = up.
  - Step counter = 0, `pwm_cnt` = 0, all `duty_q` = 0.
  - All PWM outputs = 0, `btn_q` = 1.
  - Reset mid-period or mid-ramp abandons all state immediately.

## Timing
- Button to mode: `mode` updates at the first edge where `btn_i` is sampled 1 after having been sampled 0 at the previous edge.
- Mode to PWM output: the new duty loads at the next `pwm_cnt` wrap, at most 2^PWM_BITS clocks later. `pwm_x` follows one clock after the compare.
- Output phase: `pwm_x` is high in the clocks following counter values 0..duty−1, i.e. one cycle of lag relative to `pwm_cnt`.
- Level steps: one every STEP_CYCLES clocks exactly. The first step after reset or a mode change occurs STEP_CYCLES clocks later.
- No backpressure or handshake. Inputs are assumed already synchronised and debounced.

## Structure
- Package `led_pkg`: mode enumeration (3-bit, values above), `MODE_COUNT` = 8, direction enum.
- Sub-module `led_breath_ramp`:
  - Ports: step counter, `level`, `dir`, a synchronous clear input and a `level` output.
  - Instantiated once.
- The top module holds the edge detectors, the mode FSM, the duty mux, the shared PWM counter and three compare registers.

## Test plan
Benches run with STEP_CYCLES = 4.

- Reset with both buttons held high → `mode` = 0, all PWM outputs 0. Releasing and re-pressing next → `mode` = 1 one edge after the press.
- Mode 1, STEADY_DUTY = 128 → `pwm_red` high for exactly 128 of each 256 clocks; green and blue stay 0.
- Press prev at `mode` 0 → `mode` 7. Press next at `mode` 7 → `mode` 0. Press both at the same edge → `mode` unchanged.
- Press next mid PWM period → `duty_q` changes only after `pwm_cnt` = 255; the output pulse width in the current period is unchanged.
- Mode 4 → `level` reaches 255 after 1020 clocks, then 254 after 4 more; `pwm_red` duty tracks `level` one period late.
- Assert rst_n low during BREATHE_WHITE at `level` = 100 → the next edge shows `level` = 0, `mode` = 0, all outputs 0.
